// File: rtl/sl_fifo_pkg.sv
// Shared definitions for the SL-transceiver FIFO pair: word layout, modifiers,
// bridge register offsets and FLAGS bit positions.
package sl_fifo_pkg;

  localparam int WORD_W = 34;
  localparam int HMB    = 33;
  localparam int LMB    = 32;

  localparam logic [1:0] CONFIG  = 2'd0;
  localparam logic [1:0] DATA    = 2'd1;
  localparam logic [1:0] STATUS  = 2'd2;
  localparam logic [1:0] CHANNEL = 2'd3;

  // Word offsets (paddr[5:2])
  localparam logic [3:0] OFS_CMD_CONFIG  = 4'h0;
  localparam logic [3:0] OFS_CMD_DATA    = 4'h1;
  localparam logic [3:0] OFS_CMD_STATUS  = 4'h2;
  localparam logic [3:0] OFS_CMD_CHANNEL = 4'h3;
  localparam logic [3:0] OFS_SH_CONFIG   = 4'h4;
  localparam logic [3:0] OFS_SH_DATA     = 4'h5;
  localparam logic [3:0] OFS_SH_STATUS   = 4'h6;
  localparam logic [3:0] OFS_SH_CHANNEL  = 4'h7;
  localparam logic [3:0] OFS_FLAGS       = 4'h8;
  localparam logic [3:0] OFS_IRQ_MASK    = 4'h9;
  localparam logic [3:0] OFS_FIFO_STAT   = 4'hA;

  localparam int FLG_CONFIG  = 0;
  localparam int FLG_DATA    = 1;
  localparam int FLG_STATUS  = 2;
  localparam int FLG_CHANNEL = 3;
  localparam int FLG_LOST    = 4;
  localparam int FLG_TIMEOUT = 5;
  localparam int FLG_W       = 6;

  typedef enum logic [1:0] {A_IDLE, A_WAIT_FULL, A_RESP} apb_state_t;
  typedef enum logic {R_IDLE, R_GAP} rsp_state_t;

  // The status modifier is produced by the transceiver only, never by the host.
  function automatic logic is_cmd_ofs(input logic [3:0] ofs);
    return (ofs == OFS_CMD_CONFIG) || (ofs == OFS_CMD_DATA) || (ofs == OFS_CMD_CHANNEL);
  endfunction

endpackage

// File: rtl/sl_rsp_capture.sv
// Drains the response FIFO into per-modifier shadow registers and owns FLAGS.
//   state  | meaning
//   R_IDLE | wait for a non-empty response FIFO, capture and pop the head word
//   R_GAP  | one idle cycle so the FIFO empty flag reflects the pop
module sl_rsp_capture
  import sl_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_read_empty,
  input  logic [WORD_W-1:0] fifo_read_data,
  output logic              fifo_read_inc,
  input  logic [FLG_W-1:0]  flag_clr,
  input  logic              set_timeout,
  output logic [31:0]       sh_config,
  output logic [31:0]       sh_data,
  output logic [31:0]       sh_status,
  output logic [31:0]       sh_channel,
  output logic [FLG_W-1:0]  flags
);

  rsp_state_t       state, nxt_state;
  logic             take;
  logic [1:0]       mod;
  logic [FLG_W-1:0] flag_set;

  assign mod = fifo_read_data[HMB:LMB];

  always_comb begin
    nxt_state = state;
    take      = 1'b0;
    flag_set  = '0;
    case (state)
      R_IDLE: begin
        if (!fifo_read_empty) begin
          take      = 1'b1;
          nxt_state = R_GAP;
        end
      end
      R_GAP:   nxt_state = R_IDLE;
      default: nxt_state = R_IDLE;
    endcase
    if (take) begin
      case (mod)
        CONFIG:  flag_set[FLG_CONFIG]  = 1'b1;
        DATA:    flag_set[FLG_DATA]    = 1'b1;
        STATUS:  flag_set[FLG_STATUS]  = 1'b1;
        default: flag_set[FLG_CHANNEL] = 1'b1;
      endcase
      // A data word the host has already consumed via a FLAGS read is not lost.
      if (mod == DATA && flags[FLG_DATA] && !flag_clr[FLG_DATA])
        flag_set[FLG_LOST] = 1'b1;
    end
    flag_set[FLG_TIMEOUT] = set_timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= R_IDLE;
      fifo_read_inc <= 1'b0;
      flags         <= '0;
      sh_config     <= '0;
      sh_data       <= '0;
      sh_status     <= '0;
      sh_channel    <= '0;
    end else begin
      state         <= nxt_state;
      fifo_read_inc <= take;
      flags         <= (flags & ~flag_clr) | flag_set;
      if (take) begin
        case (mod)
          CONFIG:  sh_config  <= fifo_read_data[31:0];
          DATA:    sh_data    <= fifo_read_data[31:0];
          STATUS:  sh_status  <= fifo_read_data[31:0];
          default: sh_channel <= fifo_read_data[31:0];
        endcase
      end
    end
  end

endmodule

// File: rtl/apb_2_fifo_bridge.sv
// APB3 slave bridging host accesses to the SL-transceiver command/response FIFOs.
//   state       | meaning
//   A_IDLE      | wait for an access phase and decode it
//   A_WAIT_FULL | command write stalled on a full command FIFO, timeout counting
//   A_RESP      | pready high for one cycle with registered prdata/pslverr
module apb_2_fifo_bridge
  import sl_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int FULL_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  irq,
  input  logic                  fifo_write_full,
  output logic [WORD_W-1:0]     fifo_write_data,
  output logic                  fifo_write_inc,
  input  logic                  fifo_read_empty,
  input  logic [WORD_W-1:0]     fifo_read_data,
  output logic                  fifo_read_inc
);

  localparam logic [7:0] TO_LAST = 8'(FULL_TIMEOUT - 1);

  apb_state_t        state, nxt_state;
  logic [7:0]        cnt, nxt_cnt;
  logic [31:0]       nxt_prdata;
  logic              nxt_pslverr;
  logic              nxt_push;
  logic [WORD_W-1:0] nxt_wdata;
  logic [FLG_W-1:0]  irq_mask;
  logic              mask_we;
  logic [FLG_W-1:0]  flag_clr;
  logic              set_timeout;

  logic [31:0]       sh_config, sh_data, sh_status, sh_channel;
  logic [FLG_W-1:0]  flags;

  logic [3:0]        ofs;
  logic              access, is_cmd, rd_ok, valid, unused_addr;
  logic [31:0]       rd_val;

  assign ofs         = paddr[5:2];
  assign unused_addr = ^{paddr[ADDR_WIDTH-1:6], paddr[1:0]};
  assign access      = psel & penable;
  assign is_cmd      = pwrite & is_cmd_ofs(ofs);

  always_comb begin
    rd_ok  = 1'b1;
    rd_val = '0;
    case (ofs)
      OFS_SH_CONFIG:  rd_val = sh_config;
      OFS_SH_DATA:    rd_val = sh_data;
      OFS_SH_STATUS:  rd_val = sh_status;
      OFS_SH_CHANNEL: rd_val = sh_channel;
      OFS_FLAGS:      rd_val = {{(32-FLG_W){1'b0}}, flags};
      OFS_IRQ_MASK:   rd_val = {{(32-FLG_W){1'b0}}, irq_mask};
      OFS_FIFO_STAT:  rd_val = {30'd0, fifo_read_empty, fifo_write_full};
      default:        rd_ok  = 1'b0;
    endcase
  end

  assign valid = is_cmd | (!pwrite & rd_ok) | (pwrite & (ofs == OFS_IRQ_MASK));

  always_comb begin
    nxt_state   = state;
    nxt_cnt     = cnt;
    nxt_prdata  = prdata;
    nxt_pslverr = 1'b0;
    nxt_push    = 1'b0;
    nxt_wdata   = fifo_write_data;
    mask_we     = 1'b0;
    flag_clr    = '0;
    set_timeout = 1'b0;
    case (state)
      A_IDLE: begin
        if (access) begin
          if (is_cmd) begin
            if (!fifo_write_full) begin
              nxt_push  = 1'b1;
              nxt_wdata = {ofs[1:0], pwdata};
              nxt_state = A_RESP;
            end else begin
              nxt_cnt   = '0;
              nxt_state = A_WAIT_FULL;
            end
          end else begin
            nxt_state = A_RESP;
            if (!valid) begin
              nxt_pslverr = 1'b1;
            end else if (pwrite) begin
              mask_we = 1'b1;
            end else begin
              nxt_prdata = rd_val;
              if (ofs == OFS_FLAGS) flag_clr = flags;
            end
          end
        end
      end
      A_WAIT_FULL: begin
        // APB holds paddr/pwdata stable until pready, so they need no latching.
        if (!fifo_write_full) begin
          nxt_push  = 1'b1;
          nxt_wdata = {ofs[1:0], pwdata};
          nxt_state = A_RESP;
        end else if (cnt == TO_LAST) begin
          nxt_pslverr = 1'b1;
          set_timeout = 1'b1;
          nxt_state   = A_RESP;
        end else begin
          nxt_cnt = cnt + 8'd1;
        end
      end
      A_RESP:  nxt_state = A_IDLE;
      default: nxt_state = A_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= A_IDLE;
      cnt             <= '0;
      prdata          <= '0;
      pready          <= 1'b0;
      pslverr         <= 1'b0;
      fifo_write_data <= '0;
      fifo_write_inc  <= 1'b0;
      irq_mask        <= '0;
      irq             <= 1'b0;
    end else begin
      state           <= nxt_state;
      cnt             <= nxt_cnt;
      prdata          <= nxt_prdata;
      pready          <= (nxt_state == A_RESP);
      pslverr         <= nxt_pslverr;
      fifo_write_data <= nxt_wdata;
      fifo_write_inc  <= nxt_push;
      if (mask_we) irq_mask <= pwdata[FLG_W-1:0];
      irq             <= |(flags & irq_mask);
    end
  end

  sl_rsp_capture u_rsp (
    .clk             (clk),
    .rst_n           (rst_n),
    .fifo_read_empty (fifo_read_empty),
    .fifo_read_data  (fifo_read_data),
    .fifo_read_inc   (fifo_read_inc),
    .flag_clr        (flag_clr),
    .set_timeout     (set_timeout),
    .sh_config       (sh_config),
    .sh_data         (sh_data),
    .sh_status       (sh_status),
    .sh_channel      (sh_channel),
    .flags           (flags)
  );

endmodule

// File: tb/tb_apb_2_fifo_bridge.sv
// Directed bench for apb_2_fifo_bridge with a command-push scoreboard and a
// modelled first-word-fall-through response FIFO.
module tb_apb_2_fifo_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  paddr = '0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr, irq;
  logic        fifo_write_full = 1'b0;
  logic [33:0] fifo_write_data;
  logic        fifo_write_inc;
  logic        fifo_read_empty;
  logic [33:0] fifo_read_data;
  logic        fifo_read_inc;

  int tests = 0;
  int fails = 0;

  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];

  logic [33:0] rsp_mem [64];
  logic [5:0]  wr_ptr = '0;
  logic [5:0]  rd_ptr = '0;
  int          cyc = 0;
  int          pop_cyc [64];

  assign fifo_read_empty = (wr_ptr == rd_ptr);
  assign fifo_read_data  = rsp_mem[rd_ptr];

  apb_2_fifo_bridge #(.ADDR_WIDTH(8), .FULL_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .irq(irq), .fifo_write_full(fifo_write_full),
    .fifo_write_data(fifo_write_data), .fifo_write_inc(fifo_write_inc),
    .fifo_read_empty(fifo_read_empty), .fifo_read_data(fifo_read_data),
    .fifo_read_inc(fifo_read_inc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_read_inc && (wr_ptr != rd_ptr)) begin
      pop_cyc[rd_ptr] <= cyc;
      rd_ptr <= rd_ptr + 6'd1;
    end
  end

  always @(negedge clk)
    if (rst_n && fifo_write_inc) got_q.push_back(fifo_write_data);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_rsp(input logic [33:0] w);
    rsp_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic apb(input logic [7:0] addr, input logic wr, input logic [31:0] wdata,
                     input logic inject, input logic [33:0] inj_word,
                     output logic [31:0] rdata, output logic err, output int nacc,
                     output logic seen);
    int n;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    if (inject) push_rsp(inj_word);
    n = 0; seen = 1'b0; rdata = '0; err = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (pready) begin
        seen  = 1'b1;
        rdata = prdata;
        err   = pslverr;
      end
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    nacc = n;
  endtask

  task automatic wr_reg(input string tag, input logic [7:0] addr, input logic [31:0] d,
                        input logic exp_err);
    logic [31:0] rd; logic err, seen; int n;
    apb(addr, 1'b1, d, 1'b0, '0, rd, err, n, seen);
    chk({tag, "_ready"}, 64'(seen), 64'd1);
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
  endtask

  task automatic rd_reg(input string tag, input logic [7:0] addr, input logic [31:0] exp,
                        input logic exp_err);
    logic [31:0] rd; logic err, seen; int n;
    apb(addr, 1'b0, '0, 1'b0, '0, rd, err, n, seen);
    chk({tag, "_ready"}, 64'(seen), 64'd1);
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
    if (!exp_err) chk({tag, "_data"}, 64'(rd), 64'(exp));
  endtask

  task automatic sb_check(input string tag);
    chk({tag, "_pushes"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_word"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] rd;
    logic err, seen, hit;
    int n;

    for (int i = 0; i < 64; i++) rsp_mem[i] = '0;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_prdata", 64'(prdata), 64'd0);
    chk("rst_pready", 64'(pready), 64'd0);
    chk("rst_pslverr", 64'(pslverr), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_wdata", 64'(fifo_write_data), 64'd0);
    chk("rst_strobes", 64'({fifo_write_inc, fifo_read_inc}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Plain command write
    exp_q.push_back(34'h1_DEADBEEF);
    apb(8'h04, 1'b1, 32'hDEADBEEF, 1'b0, '0, rd, err, n, seen);
    chk("cmd_data_ready", 64'(seen), 64'd1);
    chk("cmd_data_acc_cycles", 64'(n), 64'd2);
    chk("cmd_data_err", 64'(err), 64'd0);
    sb_check("cmd_data");

    // Stall on full, released after 5 cycles
    fifo_write_full = 1'b1;
    exp_q.push_back(34'h3_00000001);
    fork
      begin
        repeat (5) @(posedge clk);
        #1 fifo_write_full = 1'b0;
      end
    join_none
    apb(8'h0C, 1'b1, 32'h1, 1'b0, '0, rd, err, n, seen);
    chk("cmd_wait_ready", 64'(seen), 64'd1);
    chk("cmd_wait_err", 64'(err), 64'd0);
    sb_check("cmd_wait");

    // Full never drops: timeout
    fifo_write_full = 1'b1;
    apb(8'h0C, 1'b1, 32'h2, 1'b0, '0, rd, err, n, seen);
    chk("cmd_to_ready", 64'(seen), 64'd1);
    chk("cmd_to_err", 64'(err), 64'd1);
    chk("cmd_to_acc_cycles", 64'(n), 64'd18);
    fifo_write_full = 1'b0;
    sb_check("cmd_to");
    rd_reg("flags_to", 8'h20, 32'h20, 1'b0);
    rd_reg("flags_to_clr", 8'h20, 32'h0, 1'b0);

    // Response sorting
    push_rsp(34'h2_00000005);
    push_rsp(34'h1_12345678);
    repeat (10) @(posedge clk);
    #1;
    chk("rsp_pop_count", 64'(rd_ptr), 64'd2);
    chk("rsp_pop_gap_ok", 64'((pop_cyc[1] - pop_cyc[0]) >= 2), 64'd1);
    rd_reg("sh_status", 8'h18, 32'h5, 1'b0);
    rd_reg("sh_data", 8'h14, 32'h12345678, 1'b0);
    rd_reg("flags_rsp", 8'h20, 32'h06, 1'b0);

    // Data overrun
    push_rsp(34'h1_AAAA0001);
    push_rsp(34'h1_AAAA0002);
    repeat (10) @(posedge clk);
    rd_reg("flags_lost", 8'h20, 32'h12, 1'b0);
    rd_reg("flags_lost_clr", 8'h20, 32'h0, 1'b0);
    rd_reg("sh_data_last", 8'h14, 32'hAAAA0002, 1'b0);

    // Capture landing in the clearing cycle keeps its bit
    push_rsp(34'h0_00000011);
    repeat (6) @(posedge clk);
    apb(8'h20, 1'b0, '0, 1'b1, 34'h0_00000077, rd, err, n, seen);
    chk("flags_race_read", 64'(rd), 64'h01);
    repeat (4) @(posedge clk);
    rd_reg("flags_race_kept", 8'h20, 32'h01, 1'b0);
    rd_reg("sh_config", 8'h10, 32'h77, 1'b0);

    // Interrupt masking
    wr_reg("mask_wr", 8'h24, 32'h02, 1'b0);
    rd_reg("mask_rd", 8'h24, 32'h02, 1'b0);
    push_rsp(34'h0_00000022);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("irq_masked_cfg", 64'(irq), 64'd0);
    rd_reg("flags_cfg", 8'h20, 32'h01, 1'b0);
    @(posedge clk); #1;
    push_rsp(34'h1_00000099);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (fifo_read_inc) hit = 1'b1;
    end
    chk("irq_capture_seen", 64'(hit), 64'd1);
    chk("irq_capture_cycle", 64'(irq), 64'd0);
    @(negedge clk);
    chk("irq_rise", 64'(irq), 64'd1);
    rd_reg("flags_irq", 8'h20, 32'h02, 1'b0);
    @(negedge clk);
    chk("irq_fall", 64'(irq), 64'd0);

    // Illegal accesses
    wr_reg("err_wr_status", 8'h08, 32'h5, 1'b1);
    rd_reg("err_rd_cmd", 8'h00, 32'h0, 1'b1);
    rd_reg("err_rd_30", 8'h30, 32'h0, 1'b1);
    wr_reg("err_wr_sh", 8'h10, 32'h1, 1'b1);
    sb_check("err_no_push");
    chk("err_no_pop", 64'(rd_ptr), 64'd8);
    rd_reg("fifo_stat", 8'h28, 32'h2, 1'b0);

    // Reset while stalled in WAIT_FULL
    fifo_write_full = 1'b1;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 8'h04; pwrite = 1'b1; pwdata = 32'hBAD0BAD0;
    @(posedge clk); #1 penable = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_pready", 64'(pready), 64'd0);
    chk("rst_mid_pslverr", 64'(pslverr), 64'd0);
    chk("rst_mid_fifo", 64'({fifo_write_inc, fifo_write_data}), 64'd0);
    chk("rst_mid_misc", 64'({irq, fifo_read_inc, prdata}), 64'd0);
    psel = 1'b0; penable = 1'b0; fifo_write_full = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    sb_check("rst_mid_no_push");
    rd_reg("rst_mid_mask", 8'h24, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
